// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the 8088 HOLD/HLDA bus arbiter.
// Holds the arbiter state encoding and the round-robin pick function.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HLDA,
        GRANT,
        TURN,
        WAIT_REL
    } arb_state_t;

    // Widest requester vector the pick function accepts.
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req scanning upward from ptr, modulo num_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 num_req
    );
        rr_pick_t pick;
        int       idx;
        pick = '0;
        // Scan from the farthest offset down so the nearest set bit is written last.
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < num_req) begin
                idx = int'(ptr) + i;
                if (idx >= num_req) idx = idx - num_req;
                if (req[3'(idx)]) begin
                    pick.valid = 1'b1;
                    pick.idx   = 3'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_hold_arbiter_sync2.sv
// Two-flop synchroniser for asynchronous CPU pins such as HLDA.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops let a metastable first stage settle before q is used.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking so each flop takes its pre-edge input, giving a real two-stage chain.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_hold_arbiter.sv
// Shares the 8088 local bus between the CPU and NUM_REQ external masters via HOLD/HLDA.
// HOLD is raised on any request; once the synchronised HLDA arrives one requester is
// granted in round-robin order, for at most MAX_BURST cycles (0 = unlimited).
// Optional build macro HOLD_CHAIN_EN: from TURN, pending requests are granted directly
// while HOLD stays high, skipping the HLDA release/re-acquire handshake.
module bus_hold_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 16,
    localparam int CW        = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1,
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DONE,
    input  logic               HLDA,
    output logic               HOLD,
    output logic [NUM_REQ-1:0] GNT,
    output logic [IW-1:0]      GNT_ID,
    output logic               BUS_OE,
    output logic               TIMEOUT,
    output logic               ABORT
);

    arb_state_t         state, state_next;
    logic [IW-1:0]      rr_ptr, rr_ptr_next;
    logic [CW-1:0]      count, count_next;
    logic               hold_next, bus_oe_next, timeout_next, abort_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [IW-1:0]      gnt_id_next;
    logic               hlda_s;

    logic [MAX_REQ-1:0] req_ext;
    rr_pick_t           pick;
    logic [IW-1:0]      winner;
    logic               take_grant;
    logic               cur_done, cur_req, burst_hit, released;

    sync2 #(.WIDTH(1)) u_hlda_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (HLDA),
        .q     (hlda_s)
    );

    // Round-robin winner among the live requests, starting at rr_ptr.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = REQ;
        pick                 = rr_pick(req_ext, 3'(rr_ptr), NUM_REQ);
        winner               = IW'(pick.idx);
    end

    assign cur_done  = DONE[GNT_ID];
    assign cur_req   = REQ[GNT_ID];
    assign burst_hit = (MAX_BURST != 0) && (count == CW'(MAX_BURST - 1));
    assign released  = cur_done || !cur_req;

    // Next-state and next-output decode for the HOLD/grant sequence.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next   = state;
        hold_next    = HOLD;
        gnt_next     = GNT;
        gnt_id_next  = GNT_ID;
        bus_oe_next  = BUS_OE;
        timeout_next = 1'b0;
        abort_next   = 1'b0;
        rr_ptr_next  = rr_ptr;
        count_next   = count;
        take_grant   = 1'b0;

        case (state)
            IDLE: begin
                if (|REQ) begin
                    state_next = WAIT_HLDA;
                    hold_next  = 1'b1;
                end
            end
            WAIT_HLDA: begin
                if (hlda_s) begin
                    if (pick.valid) begin
                        take_grant = 1'b1;
                    end else begin
                        state_next = WAIT_REL;
                        hold_next  = 1'b0;
                    end
                end
            end
            GRANT: begin
                if (!hlda_s) begin
                    // CPU took the bus back: drop everything and start over.
                    state_next  = IDLE;
                    hold_next   = 1'b0;
                    gnt_next    = '0;
                    bus_oe_next = 1'b0;
                    abort_next  = 1'b1;
                    count_next  = '0;
                end else if (released || burst_hit) begin
                    state_next   = TURN;
                    gnt_next     = '0;
                    bus_oe_next  = 1'b0;
                    count_next   = '0;
                    timeout_next = burst_hit && !released;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            TURN: begin
`ifdef HOLD_CHAIN_EN
                if (pick.valid) begin
                    take_grant = 1'b1;
                end else begin
                    state_next = WAIT_REL;
                    hold_next  = 1'b0;
                end
`else
                state_next = WAIT_REL;
                hold_next  = 1'b0;
`endif
            end
            WAIT_REL: begin
                if (!hlda_s) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                hold_next  = 1'b0;
                gnt_next   = '0;
                bus_oe_next = 1'b0;
            end
        endcase

        if (take_grant) begin
            state_next           = GRANT;
            gnt_next             = '0;
            gnt_next[winner]     = 1'b1;
            gnt_id_next          = winner;
            bus_oe_next          = 1'b1;
            count_next           = '0;
            rr_ptr_next          = (pick.idx == 3'(NUM_REQ - 1)) ? '0 : IW'(pick.idx + 3'd1);
        end
    end

    // State and registered outputs; reset clears everything at once, mid-grant included.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            count   <= '0;
            HOLD    <= 1'b0;
            GNT     <= '0;
            GNT_ID  <= '0;
            BUS_OE  <= 1'b0;
            TIMEOUT <= 1'b0;
            ABORT   <= 1'b0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            count   <= count_next;
            HOLD    <= hold_next;
            GNT     <= gnt_next;
            GNT_ID  <= gnt_id_next;
            BUS_OE  <= bus_oe_next;
            TIMEOUT <= timeout_next;
            ABORT   <= abort_next;
        end
    end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Scoreboard bench for bus_hold_arbiter (default build): stimulus pushes the expected
// grant (winner, length, timeout, abort) and a monitor checks each grant as it ends.
module tb_bus_hold_arbiter;

    localparam int N     = 4;
    localparam int BURST = 16;

    localparam int M_DONE     = 0;
    localparam int M_DROP     = 1;
    localparam int M_ABORT    = 2;
    localparam int M_WITHDRAW = 3;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [N-1:0] REQ;
    logic [N-1:0] DONE;
    logic         HLDA;
    logic         HOLD;
    logic [N-1:0] GNT;
    logic [1:0]   GNT_ID;
    logic         BUS_OE;
    logic         TIMEOUT;
    logic         ABORT;

    logic [1:0] hpipe = 2'b00;
    logic       force_low = 1'b0;

    typedef struct {
        int id;
        int len;
        int to;
        int ab;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   model_ptr = 0;
    int   exp_to = 0, exp_ab = 0, seen_to = 0, seen_ab = 0;
    int   grants = 0;

    bus_hold_arbiter #(.NUM_REQ(N), .MAX_BURST(BURST)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REQ     (REQ),
        .DONE    (DONE),
        .HLDA    (HLDA),
        .HOLD    (HOLD),
        .GNT     (GNT),
        .GNT_ID  (GNT_ID),
        .BUS_OE  (BUS_OE),
        .TIMEOUT (TIMEOUT),
        .ABORT   (ABORT)
    );

    always #5 CLK = ~CLK;

    // CPU stand-in: HLDA follows HOLD two cycles later, unless forced low.
    always @(posedge CLK) begin
        #2 hpipe <= {hpipe[0], HOLD};
    end
    assign HLDA = hpipe[1] & ~force_low;

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference round robin: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] req);
        for (int i = 0; i < N; i++) begin
            if (req[(model_ptr + i) % N]) return (model_ptr + i) % N;
        end
        return -1;
    endfunction

    // Monitor: follows each grant from rise to fall and scores it against the queue.
    initial begin : monitor
        int   cyc, hlda_rise, glen, gid;
        bit   active, hlda_q, chk_hold_low;
        exp_t e;
        cyc = 0; hlda_rise = -100; active = 0; hlda_q = 0; chk_hold_low = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RESET) begin
                active       = 0;
                chk_hold_low = 0;
                hlda_q       = HLDA;
            end else begin
                if (chk_hold_low) begin
                    check("hold_drop_after_turn", HOLD, 0);
                    chk_hold_low = 0;
                end
                if (HLDA && !hlda_q) hlda_rise = cyc;
                hlda_q = HLDA;
                if (TIMEOUT) seen_to++;
                if (ABORT) seen_ab++;
                if (!active && GNT != '0) begin
                    active = 1;
                    glen   = 1;
                    gid    = GNT_ID;
                    grants++;
                    check("gnt_onehot", $countones(GNT), 1);
                    check("gnt_matches_id", GNT, 1 << GNT_ID);
                    check("bus_oe_on_grant", BUS_OE, 1);
                    check("grant_latency", cyc - hlda_rise, 3);
                end else if (active && GNT != '0) begin
                    glen++;
                    check("gnt_stable", GNT, 1 << gid);
                end else if (active) begin
                    active = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", gid, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("grant_id", gid, e.id);
                        check("grant_len", glen, e.len);
                        check("timeout_at_end", TIMEOUT, e.to);
                        check("abort_at_end", ABORT, e.ab);
                        check("bus_oe_off", BUS_OE, 0);
                        check("gnt_id_kept", GNT_ID, e.id);
                        if (e.ab != 0) check("hold_off_on_abort", HOLD, 0);
                        else begin
                            check("hold_in_turn", HOLD, 1);
                            chk_hold_low = 1;
                        end
                    end
                end
            end
        end
    end

    // Wait for the handshake to unwind and the arbiter to be back in IDLE.
    task automatic settle();
        int n;
        n = 0;
        while (HOLD !== 1'b0 && n < 60) begin tick(); n++; end
        if (n >= 60) check("hold_release_wait", HOLD, 0);
        repeat (3) tick();
        force_low = 1'b0;
        n = 0;
        while (HLDA !== 1'b0 && n < 20) begin tick(); n++; end
        if (n >= 20) check("hlda_release_wait", HLDA, 0);
        repeat (5) tick();
    endtask

    // One grant: release after k held cycles by DONE, REQ drop, or forced HLDA loss.
    task automatic run_grant(input logic [N-1:0] req, input int mode, input int k);
        exp_t e;
        int   w;
        bit   got;
        w    = model_pick(req);
        e.id = w;
        if (mode == M_ABORT) begin
            e.len = k + 3; e.to = 0; e.ab = 1;
        end else begin
            e.len = (k + 1 > BURST) ? BURST : k + 1;
            e.to  = (k + 1 > BURST) ? 1 : 0;
            e.ab  = 0;
        end
        exp_q.push_back(e);
        exp_to += e.to;
        exp_ab += e.ab;
        model_ptr = (w + 1) % N;

        REQ = req;
        tick();
        check("hold_rise", HOLD, 1);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (GNT != '0) got = 1;
        end
        if (!got) begin
            check("grant_wait", 0, 1);
            void'(exp_q.pop_back());
            exp_to -= e.to;
            exp_ab -= e.ab;
            REQ = '0;
            settle();
            return;
        end
        for (int i = 1; i <= k; i++) begin
            tick();
            // A DONE from a bystander must not end the grant.
            if (i == 1 && k >= 2 && mode == M_DONE) DONE = N'(1 << ((w + 1) % N));
            else DONE = '0;
        end
        case (mode)
            M_DONE:  DONE = N'(1 << w);
            M_DROP:  REQ = '0;
            default: force_low = 1'b1;
        endcase
        if (mode == M_ABORT) repeat (3) tick();
        else tick();
        DONE = '0;
        REQ  = '0;
        settle();
    endtask

    // Request, then withdraw before HLDA returns: no grant, HOLD released.
    task automatic run_withdraw(input logic [N-1:0] req);
        int g;
        g   = grants;
        REQ = req;
        tick();
        check("withdraw_hold_rise", HOLD, 1);
        REQ = '0;
        settle();
        check("withdraw_no_grant", grants, g);
    endtask

    initial begin : stimulus
        int mode, k;
        RESET = 1'b1;
        REQ   = '0;
        DONE  = '0;
        repeat (3) tick();
        check("rst_hold", HOLD, 0);
        check("rst_gnt", GNT, 0);
        check("rst_gnt_id", GNT_ID, 0);
        check("rst_bus_oe", BUS_OE, 0);
        check("rst_timeout", TIMEOUT, 0);
        check("rst_abort", ABORT, 0);
        RESET = 1'b0;
        repeat (2) tick();

        // All four requesting: order starts at 0 and rotates.
        for (int i = 0; i < 5; i++) run_grant(4'b1111, M_DONE, 3);
        run_grant(4'b0010, M_DONE, 3);
        // Burst limit, and the boundary where DONE coincides with the limit.
        run_grant(4'b0001, M_DONE, 19);
        run_grant(4'b0100, M_DONE, 15);
        run_grant(4'b1000, M_DROP, 15);
        run_grant(4'b0001, M_ABORT, 5);
        run_withdraw(4'b0110);

        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == M_WITHDRAW) begin
                run_withdraw(N'($urandom_range(1, 15)));
            end else begin
                k = (mode == M_ABORT) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 19));
                run_grant(N'($urandom_range(1, 15)), mode, k);
            end
        end

        // Reset in the middle of a grant: outputs clear at once, pointer restarts at 0.
        REQ = 4'b0001;
        k   = 0;
        while (GNT == '0 && k < 30) begin tick(); k++; end
        if (k >= 30) check("pre_reset_grant_wait", 0, 1);
        repeat (3) tick();
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("midrst_hold", HOLD, 0);
        check("midrst_gnt", GNT, 0);
        check("midrst_bus_oe", BUS_OE, 0);
        check("midrst_timeout", TIMEOUT, 0);
        check("midrst_abort", ABORT, 0);
        check("midrst_gnt_id", GNT_ID, 0);
        REQ = '0;
        repeat (5) tick();
        RESET     = 1'b0;
        model_ptr = 0;
        tick();
        run_grant(4'b0011, M_DONE, 3);
        run_grant(4'b1000, M_DONE, 3);

        check("queue_empty", exp_q.size(), 0);
        check("timeout_pulses", seen_to, exp_to);
        check("abort_pulses", seen_ab, exp_ab);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
